// File: rtl/cpu_pkg.sv
// Shared core definitions: forwarding-select encodings, control-bit
// positions and ALU operation codes used by the ID/EX stage.
package cpu_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_WB = 2'b01;
  localparam logic [1:0] FWD_EX = 2'b10;

  localparam int CTRL_W        = 8;
  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_MEMREAD  = 5;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_ALUSRC   = 3;
  localparam int CTRL_REGDST   = 2;
  localparam int CTRL_ALUOP_HI = 1;
  localparam int CTRL_ALUOP_LO = 0;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSV   = 2'b11
  } alu_op_e;

  function automatic alu_op_e ctrl_aluop(
    input logic [CTRL_W-1:0] c
  );
    return alu_op_e'(c[CTRL_ALUOP_HI:CTRL_ALUOP_LO]);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// One ALU operand's forwarding select: newest writer wins, $0 never
// forwards. Compare logic exists only when ID_EX_FWD_EN is defined.
module fwd_select
  import cpu_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] src,
  input  logic          ex_regwrite,
  input  logic [AW-1:0] ex_addr,
  input  logic          mem_regwrite,
  input  logic [AW-1:0] mem_addr,
  output logic [1:0]    sel
);

`ifdef ID_EX_FWD_EN
  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = ex_regwrite
                && (ex_addr != '0)
                && (ex_addr == src);
  assign mem_hit = mem_regwrite
                && (mem_addr != '0)
                && (mem_addr == src);

  // both hits may be set; the EX-side one is the newer value
  always_comb begin
    sel = FWD_RF;
    priority case (1'b1)
      ex_hit:  sel = FWD_EX;
      mem_hit: sel = FWD_WB;
      default: sel = FWD_RF;
    endcase
  end
`else
  logic unused_fwd;

  assign unused_fwd = ^{src, ex_regwrite, ex_addr,
                        mem_regwrite, mem_addr};
  assign sel = FWD_RF;
`endif

endmodule

// File: rtl/id_ex_forward_reg.sv
// ID/EX pipeline register with registered operand-forwarding selects.
// Define ID_EX_FWD_EN to build the forwarding compare logic.
module id_ex_forward_reg
  import cpu_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [DW-1:0]     id_rs_data_i,
  input  logic [DW-1:0]     id_rt_data_i,
  input  logic [DW-1:0]     id_imm_i,
  input  logic [AW-1:0]     id_rs_i,
  input  logic [AW-1:0]     id_rt_i,
  input  logic [AW-1:0]     id_rd_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic              mem_regwrite_i,
  input  logic [AW-1:0]     mem_wr_addr_i,
  output logic              ex_valid_o,
  output logic [DW-1:0]     ex_rs_data_o,
  output logic [DW-1:0]     ex_rt_data_o,
  output logic [DW-1:0]     ex_imm_o,
  output logic [AW-1:0]     ex_rs_o,
  output logic [AW-1:0]     ex_rt_o,
  output logic [AW-1:0]     ex_rd_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [AW-1:0]     ex_wr_addr_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o
);

  logic          ex_regwrite;
  logic          bubble;
  logic [AW-1:0] wr_addr_d;
  logic [1:0]    fwd_a_d;
  logic [1:0]    fwd_b_d;

  assign ex_regwrite = ex_ctrl_o[CTRL_REGWRITE];
  assign bubble      = rst_i | flush_i | ~id_valid_i;
  assign wr_addr_d   = id_ctrl_i[CTRL_REGDST]
                     ? id_rd_i : id_rt_i;

  // current ID/EX is next cycle's EX/MEM; current EX/MEM is next MEM/WB
  fwd_select #(.AW(AW)) u_fwd_a (
    .src          (id_rs_i),
    .ex_regwrite  (ex_regwrite),
    .ex_addr      (ex_wr_addr_o),
    .mem_regwrite (mem_regwrite_i),
    .mem_addr     (mem_wr_addr_i),
    .sel          (fwd_a_d)
  );

  fwd_select #(.AW(AW)) u_fwd_b (
    .src          (id_rt_i),
    .ex_regwrite  (ex_regwrite),
    .ex_addr      (ex_wr_addr_o),
    .mem_regwrite (mem_regwrite_i),
    .mem_addr     (mem_wr_addr_i),
    .sel          (fwd_b_d)
  );

  always_ff @(posedge clk_i) begin
    if (bubble) begin
      ex_valid_o   <= 1'b0;
      ex_rs_data_o <= '0;
      ex_rt_data_o <= '0;
      ex_imm_o     <= '0;
      ex_rs_o      <= '0;
      ex_rt_o      <= '0;
      ex_rd_o      <= '0;
      ex_ctrl_o    <= '0;
      ex_wr_addr_o <= '0;
      fwd_a_o      <= FWD_RF;
      fwd_b_o      <= FWD_RF;
    end else begin
      ex_valid_o   <= 1'b1;
      ex_rs_data_o <= id_rs_data_i;
      ex_rt_data_o <= id_rt_data_i;
      ex_imm_o     <= id_imm_i;
      ex_rs_o      <= id_rs_i;
      ex_rt_o      <= id_rt_i;
      ex_rd_o      <= id_rd_i;
      ex_ctrl_o    <= id_ctrl_i;
      ex_wr_addr_o <= wr_addr_d;
      fwd_a_o      <= fwd_a_d;
      fwd_b_o      <= fwd_b_d;
    end
  end

endmodule

// File: tb/tb_id_ex_forward_reg.sv
// Bench for id_ex_forward_reg: directed pipeline table, reset cases,
// and random stimulus against a reference model.
module tb_id_ex_forward_reg;

`ifdef ID_EX_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        r_rst, r_flush, r_valid;
  logic [31:0] r_rsd, r_rtd, r_imm;
  logic [4:0]  r_rs, r_rt, r_rd;
  logic [7:0]  r_ctrl;
  logic        r_mrw;
  logic [4:0]  r_maddr;

  logic        ex_valid;
  logic [31:0] ex_rsd, ex_rtd, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_wa;
  logic [7:0]  ex_ctrl;
  logic [1:0]  fwd_a, fwd_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  id_ex_forward_reg #(.DW(32), .AW(5)) dut (
    .clk_i          (clk),
    .rst_i          (r_rst),
    .flush_i        (r_flush),
    .id_valid_i     (r_valid),
    .id_rs_data_i   (r_rsd),
    .id_rt_data_i   (r_rtd),
    .id_imm_i       (r_imm),
    .id_rs_i        (r_rs),
    .id_rt_i        (r_rt),
    .id_rd_i        (r_rd),
    .id_ctrl_i      (r_ctrl),
    .mem_regwrite_i (r_mrw),
    .mem_wr_addr_i  (r_maddr),
    .ex_valid_o     (ex_valid),
    .ex_rs_data_o   (ex_rsd),
    .ex_rt_data_o   (ex_rtd),
    .ex_imm_o       (ex_imm),
    .ex_rs_o        (ex_rs),
    .ex_rt_o        (ex_rt),
    .ex_rd_o        (ex_rd),
    .ex_ctrl_o      (ex_ctrl),
    .ex_wr_addr_o   (ex_wa),
    .fwd_a_o        (fwd_a),
    .fwd_b_o        (fwd_b)
  );

  typedef struct {
    logic        v;
    logic [31:0] rsd, rtd, imm;
    logic [4:0]  rs, rt, rd, wa;
    logic [7:0]  ctrl;
    logic [1:0]  fa, fb;
  } st_t;

  typedef struct {
    logic       flush, valid;
    logic [4:0] rs, rt, rd;
    logic [7:0] ctrl;
    logic       mrw;
    logic [4:0] maddr;
    logic       ev;
    logic [1:0] ea, eb;
  } vec_t;

  st_t  m;
  vec_t tbl[14];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else
      passed++;
  endtask

  // writers ordered newest first: the one entering EX/MEM, then MEM/WB
  function automatic logic [1:0] pick(logic [4:0] src, st_t cur);
    logic       rw[2];
    logic [4:0] wa[2];
    if (!FWD_ON) return 2'b00;
    rw[0] = cur.ctrl[7]; wa[0] = cur.wa;
    rw[1] = r_mrw;       wa[1] = r_maddr;
    for (int k = 0; k < 2; k++)
      if (rw[k] && wa[k] != 5'd0 && wa[k] == src)
        return (k == 0) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic st_t model_next(st_t cur);
    st_t n;
    n = '{default: '0};
    if (!(r_rst || r_flush || !r_valid)) begin
      n.v    = 1'b1;
      n.rsd  = r_rsd;
      n.rtd  = r_rtd;
      n.imm  = r_imm;
      n.rs   = r_rs;
      n.rt   = r_rt;
      n.rd   = r_rd;
      n.ctrl = r_ctrl;
      n.wa   = r_ctrl[2] ? r_rd : r_rt;
      n.fa   = pick(r_rs, cur);
      n.fb   = pick(r_rt, cur);
    end
    return n;
  endfunction

  task automatic cmp_all(string tag);
    chk({tag, "_valid"}, 32'(ex_valid), 32'(m.v));
    chk({tag, "_rsd"},   ex_rsd, m.rsd);
    chk({tag, "_rtd"},   ex_rtd, m.rtd);
    chk({tag, "_imm"},   ex_imm, m.imm);
    chk({tag, "_rs"},    32'(ex_rs), 32'(m.rs));
    chk({tag, "_rt"},    32'(ex_rt), 32'(m.rt));
    chk({tag, "_rd"},    32'(ex_rd), 32'(m.rd));
    chk({tag, "_ctrl"},  32'(ex_ctrl), 32'(m.ctrl));
    chk({tag, "_wa"},    32'(ex_wa), 32'(m.wa));
    chk({tag, "_fwda"},  32'(fwd_a), 32'(m.fa));
    chk({tag, "_fwdb"},  32'(fwd_b), 32'(m.fb));
  endtask

  task automatic step(string tag);
    st_t nxt;
    nxt = model_next(m);
    @(posedge clk);
    #1;
    m = nxt;
    cmp_all(tag);
  endtask

  task automatic rand_data();
    r_rsd = $urandom;
    r_rtd = $urandom;
    r_imm = $urandom;
  endtask

  initial begin
    m = '{default: '0};
    // flush, valid, rs, rt, rd, ctrl, mem_rw, mem_addr, exp valid, a, b
    tbl[0]  = '{0, 1,  1,  2,  3, 8'h86, 0,  0, 1, 2'b00, 2'b00};
    tbl[1]  = '{0, 1,  3,  5,  4, 8'h86, 0,  0, 1, 2'b10, 2'b00};
    tbl[2]  = '{0, 1,  3,  7,  6, 8'h86, 1,  3, 1, 2'b01, 2'b00};
    tbl[3]  = '{0, 1,  4,  3,  8, 8'h86, 1,  4, 1, 2'b01, 2'b00};
    tbl[4]  = '{0, 1,  8,  6,  8, 8'h86, 1,  6, 1, 2'b10, 2'b01};
    tbl[5]  = '{0, 1,  8,  0,  9, 8'h86, 1,  8, 1, 2'b10, 2'b00};
    tbl[6]  = '{0, 1,  1,  2,  0, 8'h86, 1,  8, 1, 2'b00, 2'b00};
    tbl[7]  = '{0, 1,  0,  0, 10, 8'h86, 1,  9, 1, 2'b00, 2'b00};
    tbl[8]  = '{1, 1, 10, 11,  0, 8'hE8, 1,  0, 0, 2'b00, 2'b00};
    tbl[9]  = '{0, 1, 11, 10, 12, 8'h86, 1, 10, 1, 2'b00, 2'b01};
    tbl[10] = '{0, 0,  1,  2, 13, 8'h86, 0,  0, 0, 2'b00, 2'b00};
    tbl[11] = '{0, 1, 13, 12, 14, 8'h86, 1, 12, 1, 2'b00, 2'b01};
    tbl[12] = '{0, 1, 14, 12,  0, 8'h18, 0,  0, 1, 2'b10, 2'b00};
    tbl[13] = '{0, 1, 12, 12, 15, 8'h86, 1, 14, 1, 2'b00, 2'b00};

    r_rst = 1'b1; r_flush = 1'b0; r_valid = 1'b1;
    r_rs = 5'd0; r_rt = 5'd0; r_rd = 5'd0;
    r_ctrl = 8'h00; r_mrw = 1'b0; r_maddr = 5'd0;
    rand_data();
    @(negedge clk);

    // reset with live-looking inputs
    r_rs = 5'd3; r_rt = 5'd3; r_rd = 5'd3;
    r_ctrl = 8'h86; r_mrw = 1'b1; r_maddr = 5'd3;
    step("reset");
    chk("reset_valid0", 32'(ex_valid), 32'd0);

    r_rst = 1'b0;
    foreach (tbl[i]) begin
      r_flush = tbl[i].flush;
      r_valid = tbl[i].valid;
      r_rs    = tbl[i].rs;
      r_rt    = tbl[i].rt;
      r_rd    = tbl[i].rd;
      r_ctrl  = tbl[i].ctrl;
      r_mrw   = tbl[i].mrw;
      r_maddr = tbl[i].maddr;
      rand_data();
      step($sformatf("row%0d", i));
      chk($sformatf("row%0d_tvalid", i),
          32'(ex_valid), 32'(tbl[i].ev));
      chk($sformatf("row%0d_tfwda", i),
          32'(fwd_a), FWD_ON ? 32'(tbl[i].ea) : 32'd0);
      chk($sformatf("row%0d_tfwdb", i),
          32'(fwd_b), FWD_ON ? 32'(tbl[i].eb) : 32'd0);
      if (!tbl[i].ev)
        chk($sformatf("row%0d_tctrl0", i), 32'(ex_ctrl), 32'd0);
    end

    // mid-stream reset drops a writer of $5
    r_rst = 1'b1; r_flush = 1'b0; r_valid = 1'b1;
    r_rs = 5'd1; r_rt = 5'd2; r_rd = 5'd5;
    r_ctrl = 8'h86; r_mrw = 1'b0; r_maddr = 5'd0;
    rand_data();
    step("midrst");
    r_rst = 1'b0;
    r_rs = 5'd5; r_rt = 5'd5; r_rd = 5'd6;
    rand_data();
    step("postrst");
    chk("postrst_valid", 32'(ex_valid), 32'd1);
    chk("postrst_fwda", 32'(fwd_a), 32'd0);
    // now the post-reset capture is a real dist-1 writer of $6
    r_rs = 5'd6; r_rt = 5'd1; r_rd = 5'd7;
    rand_data();
    step("postrst2");
    chk("postrst2_fwda", 32'(fwd_a), FWD_ON ? 32'd2 : 32'd0);

    for (int c = 0; c < 400; c++) begin
      r_rst   = ($urandom_range(0, 39) == 0);
      r_flush = ($urandom_range(0, 7) == 0);
      r_valid = ($urandom_range(0, 7) != 0);
      r_rs    = 5'($urandom_range(0, 7));
      r_rt    = 5'($urandom_range(0, 7));
      r_rd    = 5'($urandom_range(0, 7));
      r_ctrl  = 8'($urandom);
      r_mrw   = 1'($urandom_range(0, 1));
      r_maddr = 5'($urandom_range(0, 7));
      rand_data();
      step("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/id_ex_forward_reg.md
# id_ex_forward_reg

ID/EX pipeline register of the 5-stage core with registered forwarding-select generation. Captures decoded operands, immediate, register addresses and control bits from ID each cycle and presents them to EX. Also precomputes the 2-bit selects that steer the two 3:1 ALU operand muxes (00 = register-file value, 01 = MEM/WB write-back data, 1x = EX/MEM ALU result). Inserts a bubble on flush (load-use stall or branch taken).

## Interface
Parameters:
- DW, 32, datapath width
- AW, 5, register address width

Ports (reset is synchronous, active-high, single clock clk_i):
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  load bubble instead of ID contents
- id_valid_i  in  1  ID holds a real instruction
- id_rs_data_i, id_rt_data_i  in  DW  register-file read data
- id_imm_i  in  DW  sign-extended immediate
- id_rs_i, id_rt_i, id_rd_i  in  AW  source/destination addresses
- id_ctrl_i  in  8  {RegWrite, MemToReg, MemRead, MemWrite, ALUSrc, RegDst, ALUOp[1:0]}
- mem_regwrite_i  in  1  RegWrite of instruction now in EX/MEM
- mem_wr_addr_i  in  AW  destination of instruction now in EX/MEM
- ex_valid_o  out  1
- ex_rs_data_o, ex_rt_data_o, ex_imm_o  out  DW
- ex_rs_o, ex_rt_o, ex_rd_o  out  AW
- ex_ctrl_o  out  8
- ex_wr_addr_o  out  AW  resolved destination (RegDst ? rd : rt)
- fwd_a_o, fwd_b_o  out  2  operand-A/B mux selects

## Operation
- Every cycle one of three actions, priority order: rst_i → all state 0; flush_i → bubble (valid 0, ctrl 0, addresses 0, data 0, selects 00); else capture ID inputs.
- id_valid_i = 0 without flush: captured as bubble (ctrl forced 0).
- No hold/stall input: the register always advances; stalls are realised upstream (PC, IF/ID hold) plus flush_i here.
- Forwarding is computed one cycle early from the instruction moving into EX:
  - next EX/MEM instruction = current ID/EX contents (internal ex_ctrl RegWrite, ex_wr_addr_o).
  - next MEM/WB instruction = current EX/MEM (mem_regwrite_i, mem_wr_addr_i).
- Per operand (A uses id_rs_i, B uses id_rt_i), captured select:
  - 10 if internal RegWrite = 1, ex_wr_addr_o ≠ 0, ex_wr_addr_o = source.
  - else 01 if mem_regwrite_i = 1, mem_wr_addr_i ≠ 0, mem_wr_addr_i = source.
  - else 00.
- EX-side match has priority over MEM-side (most recent writer wins).
- Address 0 never forwards.
- Bubbles in ID/EX never forward (ctrl is 0).
- Same-cycle WB write vs. ID read is handled by the register file's write-before-read, not by this block.
- fwd_b_o is computed regardless of ALUSrc; EX ignores it when the immediate is selected.

## Timing
- Latency: 1 cycle ID→EX for all outputs, including selects.
- All outputs are registered, with no combinational input→output paths.
- Reset: every output 0, including ex_valid_o = 0 and fwd_a_o = fwd_b_o = 00.
- flush_i and a valid ID in the same cycle: flush wins, and the ID instruction is dropped (upstream re-presents it).
- rst_i asserted mid-stream: contents lost next edge; first post-reset capture is normal.
- Back-to-back dependent instructions (dist 1) → select 10; dist 2 → 01; dist ≥3 → 00.

## Configuration
- ID_EX_FWD_EN defined: forwarding logic as above.
- ID_EX_FWD_EN undefined: fwd_a_o, fwd_b_o constant 00 and the comparator logic is removed; the hazard unit must stall all RAW hazards. Pipeline register behaviour is unchanged.

## Structure
- Shared package cpu_pkg:
  - select encodings FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_EX = 2'b10
  - ctrl bit-index constants
  - ALUOp typedef
- Sub-module fwd_select: one operand's combinational priority compare (source, two writer RegWrite/addr pairs → 2-bit select). Instantiated twice, for A and B.

## Test plan
- Reset: rst_i = 1 with random inputs → next cycle all outputs 0, ex_valid_o = 0.
- Dist-1 RAW: `add $3,$1,$2` then `sub $4,$3,$5` → second instruction in EX with fwd_a_o = 10, fwd_b_o = 00.
- Dist-2 RAW plus priority:
  - `$3` written at dist 2 only → fwd = 01.
  - `$3` written at both dist 1 and dist 2 → fwd = 10.
- Register 0: writer with rd = 0 followed by a reader of $0 → fwd = 00.
- Flush vs. capture: flush_i = 1 with valid `lw` in ID → ex_valid_o = 0, ex_ctrl_o = 0. The following instruction reading a bubble's addresses → fwd = 00.
- Macro off: build without ID_EX_FWD_EN, rerun the dist-1 case → fwd_a_o = 00, all data and ctrl outputs identical to the enabled build.
